// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide unit. It runs a radix-2 shift-add
// multiply or a restoring divide on operand magnitudes, then applies the sign in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH         = 32,
  parameter bit DIVZERO_CLEAR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_next_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_mag_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_busy, r_done, r_div_zero;

  logic                 w_accept, w_dz_req, w_last;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift, w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  // Handshake: start is sampled only in IDLE; abort beats start in the same cycle
  // and cancels CALC/FIX on the next edge; done is a one-cycle registered pulse.
  assign w_accept = start & ~abort;
  assign w_dz_req = w_accept & op[1] & (b == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -a : a;
  assign w_mag_b = w_b_neg ? -b : b;

  // Multiply: the multiplier sits in the low half and shifts out as the sum shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: the remainder is in the high half and quotient bits fill the low half.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_dz_req) w_next_state = S_CALC;
      S_CALC: begin
        if (abort)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_FIX;
      end
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dz_req) begin
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
            if (DIVZERO_CLEAR) begin
              r_hi <= '0;
              r_lo <= '0;
            end
          end else if (w_accept) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_mag_b  <= w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          if (abort) begin
            r_busy <= 1'b0;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (!abort) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: two 32-bit instances (div-by-zero keep/clear)
// and one 8-bit instance, with hand-computed expected values.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  int          edge_cnt;
  int          vectors;
  int          miscompares;
  int          start_edge;
  int          lat;
  int          seen;

  logic        start32, abort32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy0, done0, dz0, busy1, done1, dz1;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic [1:0]  st0, st1;

  logic        start8, abort8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic [1:0]  st8;

  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  muldiv_unit #(.WIDTH(32), .DIVZERO_CLEAR(1'b0)) u_keep (
    .clk(clk), .reset(rst_n), .start(start32), .abort(abort32), .op(op32), .a(a32), .b(b32),
    .busy(busy0), .done(done0), .div_zero(dz0), .hi(hi0), .lo(lo0), .dbg_state(st0));

  muldiv_unit #(.WIDTH(32), .DIVZERO_CLEAR(1'b1)) u_clear (
    .clk(clk), .reset(rst_n), .start(start32), .abort(abort32), .op(op32), .a(a32), .b(b32),
    .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1), .dbg_state(st1));

  muldiv_unit #(.WIDTH(8), .DIVZERO_CLEAR(1'b0)) u_w8 (
    .clk(clk), .reset(rst_n), .start(start8), .abort(abort8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8), .dbg_state(st8));

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one-cycle start pulse, then scramble operands to show they are not re-sampled.
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait_done32(output int l);
    int n;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done32_seen", {63'd0, done0}, 64'd1);
    l = edge_cnt - start_edge;
  endtask

  task automatic wait_done8(output int l);
    int n;
    n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done8_seen", {63'd0, done8}, 64'd1);
    l = edge_cnt - start_edge;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    start32 = 1'b0; abort32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8 = 1'b0; abort8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;

    // Reset state
    #12;
    check("rst_busy", {63'd0, busy0}, 64'd0);
    check("rst_done", {63'd0, done0}, 64'd0);
    check("rst_dz",   {63'd0, dz0}, 64'd0);
    check("rst_hilo", {hi0, lo0}, 64'd0);
    check("rst_state", {62'd0, st0}, 64'd0);
    #11 rst_n = 1'b1;

    // 1: mult -3 * 7, multu 0xFFFFFFFF * 2
    issue32(2'b00, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy", {63'd0, busy0}, 64'd1);
    wait_done32(lat);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_hilo", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_busy_done", {63'd0, busy0}, 64'd0);
    @(negedge clk);
    check("mult_done_pulse", {63'd0, done0}, 64'd0);

    issue32(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_done32(lat);
    check("multu_hilo", {hi0, lo0}, 64'h0000_0001_FFFF_FFFE);

    // 2: divides, including the most-negative / -1 wrap
    issue32(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done32(lat);
    check("div_latency", 64'(lat), 64'd33);
    check("div_hilo", {hi0, lo0}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue32(2'b11, 32'd100, 32'd7);
    wait_done32(lat);
    check("divu_hilo", {hi0, lo0}, 64'h0000_0002_0000_000E);

    issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(lat);
    check("div_ovf_hilo", {hi0, lo0}, 64'h0000_0000_8000_0000);
    check("div_ovf_hilo_clr_inst", {hi1, lo1}, 64'h0000_0000_8000_0000);

    // 3: divide by zero
    issue32(2'b10, 32'd5, 32'd0);
    check("dz_done", {63'd0, done0}, 64'd1);
    check("dz_flag", {63'd0, dz0}, 64'd1);
    check("dz_busy", {63'd0, busy0}, 64'd0);
    check("dz_keep_hilo", {hi0, lo0}, 64'h0000_0000_8000_0000);
    check("dz_clear_hilo", {hi1, lo1}, 64'd0);
    check("dz_clear_flag", {62'd0, dz1, done1}, 64'd3);
    @(negedge clk);
    check("dz_pulse_end", {61'd0, busy0, dz0, done0}, 64'd0);

    // 4: abort sampled at edge 11, then a start pulse during a run
    issue32(2'b00, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    check("abort_busy_before", {63'd0, busy0}, 64'd1);
    abort32 = 1'b1;
    @(negedge clk);
    abort32 = 1'b0;
    check("abort_busy_after", {63'd0, busy0}, 64'd0);
    check("abort_state", {62'd0, st0}, 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 || done1) seen = 1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hilo", {hi0, lo0}, 64'h0000_0000_8000_0000);

    issue32(2'b00, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start32 = 1'b1; op32 = 2'b01; a32 = 32'd100; b32 = 32'd100;
    @(negedge clk);
    start32 = 1'b0;
    wait_done32(lat);
    check("ignored_start_latency", 64'(lat), 64'd33);
    check("ignored_start_hilo", {hi0, lo0}, 64'd42);

    // 5: asynchronous reset in the low clock phase during CALC
    issue32(2'b11, 32'd50, 32'd5);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy0}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy_done", {62'd0, busy0, done0}, 64'd0);
    check("async_rst_hilo", {hi0, lo0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue32(2'b11, 32'd9, 32'd3);
    wait_done32(lat);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_divu", {hi0, lo0}, 64'h0000_0000_0000_0003);

    // 6: 8-bit instance, signed -128 * -128, then back-to-back multu 255 * 255
    @(negedge clk);
    op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    start_edge = edge_cnt + 1;
    exp_q.push_back(16'h4000);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat);
    check("w8_latency", 64'(lat), 64'd9);
    exp_v = exp_q.pop_front();
    check("w8_mult_hilo", {48'd0, hi8, lo8}, {48'd0, exp_v});

    op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    start_edge = edge_cnt + 1;
    exp_q.push_back(16'hFE01);
    @(negedge clk);
    start8 = 1'b0;
    check("w8_b2b_busy", {63'd0, busy8}, 64'd1);
    wait_done8(lat);
    check("w8_b2b_latency", 64'(lat), 64'd9);
    exp_v = exp_q.pop_front();
    check("w8_b2b_hilo", {48'd0, hi8, lo8}, {48'd0, exp_v});
    check("w8_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the separate fixed-32-bit mult and div blocks.
- Supports signed and unsigned operation at any even WIDTH, with a start/busy/done handshake, abort, and a div-by-zero mode.
- Sits beside the ALU. It takes the A/B register outputs and feeds the Hi/Lo select muxes.
- The control FSM starts an operation and stalls until done.

Parameters:
WIDTH, 32, operand width in bits; legal values are even integers >= 4.
DIVZERO_CLEAR, 0, 0 = hi/lo keep their previous value on divide-by-zero; 1 = hi/lo are cleared to 0.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
abort  input  1  synchronous cancel of the current operation.
op  input  2  00 = mult signed, 01 = multu, 10 = div signed, 11 = divu; sampled with start.
a  input  WIDTH  multiplicand / dividend; sampled with start.
b  input  WIDTH  multiplier / divisor; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when hi/lo are updated or div-by-zero is flagged.
div_zero  output  1  one-cycle pulse, concurrent with done, when a div op has b == 0.
hi  output  WIDTH  mult: upper half of product; div: remainder.
lo  output  WIDTH  mult: lower half of product; div: quotient.

Behaviour:
- Reset (reset == 0, asynchronous):
  - FSM goes to IDLE; the iteration counter is cleared.
  - busy, done, div_zero, hi and lo are all 0.
- States: IDLE -> CALC -> FIX -> IDLE. All outputs are registered.
- IDLE:
  - On a clock edge with start == 1 and abort == 0: latch op, a and b.
  - For signed ops, also latch the absolute values and the result signs.
  - Go to CALC and set busy = 1.
  - If start == 1 and abort == 1 together, abort wins: the FSM stays in IDLE.
- Divide-by-zero:
  - Condition: op[1] == 1 and b == 0 at the start edge.
  - FSM stays in IDLE; busy stays 0.
  - done = 1 and div_zero = 1 for exactly one cycle after that edge.
  - hi/lo follow DIVZERO_CLEAR.
- CALC:
  - Runs exactly WIDTH iterations, one per cycle.
  - Mult uses radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
  - Div uses restoring division on magnitudes.
  - After iteration WIDTH, go to FIX.
- FIX (one cycle):
  - Apply the sign correction.
  - Mult: negate the 2*WIDTH product when the operand signs differ.
  - Div: the quotient truncates toward zero (negated if signs differ); the remainder takes the sign of the dividend.
  - Write hi/lo and pulse done for one cycle; set busy = 0; return to IDLE.
- Latency:
  - The start edge is edge 0; CALC occupies edges 1..WIDTH; FIX is edge WIDTH+1.
  - done, hi and lo are visible after edge WIDTH+1; that is 33 edges for WIDTH = 32.
  - Back-to-back operation: start may be asserted in the cycle done is high, and it is accepted.
- start while busy: ignored; no queuing.
- Operands: a and b may change after the start edge without effect.
- abort while busy (CALC or FIX): next edge returns to IDLE with busy = 0. No done pulse is generated and hi/lo are unchanged.
- Overflow case: signed div of the most-negative value by -1 gives lo = most-negative value and hi = 0 (wraps, no flag).
- Unsigned ops: operands are treated as WIDTH-bit unsigned; the product is 2*WIDTH bits and has no overflow.
- hi/lo hold their value between operations; they change only on a FIX edge or a DIVZERO_CLEAR event.

Test Plan:
1. mult, a = 0xFFFFFFFD (-3), b = 7 -> after 33 edges: done = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. multu, a = 0xFFFFFFFF, b = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE.
2. div, a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu, a = 100, b = 7 -> lo = 0x0000000E, hi = 0x00000002. div, a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
3. Load hi/lo with a prior result, then div with b = 0 -> done and div_zero high one cycle after start, busy never 1. With DIVZERO_CLEAR = 0, hi/lo are unchanged; with DIVZERO_CLEAR = 1, hi = lo = 0.
4. Run a mult and assert abort at edge 10 -> busy low after edge 11, no done pulse, hi/lo unchanged. Pulse start again at edge 5 of a running op -> ignored, result and timing unaffected.
5. Drop reset asynchronously (mid-clock) during CALC -> busy, done, hi and lo go to 0 immediately, with no clock edge. After release, a new divu 9/3 gives lo = 3, hi = 0.
6. WIDTH = 8 instance: mult, a = 0x80 (-128), b = 0x80 -> done after edge 9, hi = 0x40, lo = 0x00. Back-to-back start in the done cycle -> second result after a further 9 edges.
